gfx_frame_scheduler: RTL
========================

Name: gfx_frame_scheduler

Overview:
Sequences the graphics-side frame buffer write path. Generates the GBA dot/line timing (308 dots x 228 lines, 4 clk per dot) and the linear write address and enable for the back buffer. Produces HBlank/VBlank/VCount status and interrupt pulses. At VBlank entry it runs a req/ack swap handshake with the double-buffer owner, and counts dropped swaps.

Parameters:
DOT_CLKS, 4, clk cycles per dot
H_VISIBLE, 240, visible dots per line
H_TOTAL, 308, dots per line
V_VISIBLE, 160, visible lines per frame
V_TOTAL, 228, lines per frame

Ports:
clk  in  1  single clock
rst_b  in  1  asynchronous active-low reset
en  in  1  timing enable; low freezes all counters
lyc  in  8  VCount compare value (DISPSTAT[15:8])
swap_ack  in  1  buffer owner accepts swap
dot_strobe  out  1  high on last clk of each dot
hcount  out  9  current dot, 0..H_TOTAL-1
vcount  out  8  current line, 0..V_TOTAL-1
pix_wen  out  1  back-buffer write enable
pix_addr  out  17  back-buffer address, 0..38399
hblank  out  1  hcount >= H_VISIBLE
vblank  out  1  vcount in [V_VISIBLE, V_TOTAL-2]
vcount_match  out  1  vcount == lyc
hblank_irq, vblank_irq, vcount_irq  out  1 each  one-clk pulses
swap_req  out  1  swap request to buffer owner
front_sel  out  1  buffer currently displayed (0/1)
frame_drop  out  1  one-clk pulse when a swap is abandoned

Behaviour:
- Reset (async, rst_b low): all counters, pix_addr, swap_req, front_sel and the irq/drop pulses go to 0. Level outputs are derived from 0 counters: hblank=0, vblank=0, vcount_match=(lyc==0).
- Divider 0..DOT_CLKS-1 advances every clk while en=1. dot_strobe = en & (div==DOT_CLKS-1). Combinational from registers.
- On dot_strobe, hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount wraps V_TOTAL-1 -> 0. Frame period = 280896 clk.
- pix_wen = dot_strobe & hcount<H_VISIBLE & vcount<V_VISIBLE. It is combinational, so one write per visible dot, on the dot's last clk.
- pix_addr increments on each cycle with pix_wen=1, saturating behaviour not allowed: it wraps to 0 at the frame wrap (vcount 227->0, hcount 307->0). It equals vcount*240+hcount during the visible area and holds 38400-wrapped-to-0 after the last visible write (38399 -> 0).
- irq pulses are registered, high exactly one clk, in the cycle after the counter update that enters the condition:
  - hblank_irq: hcount 239->240.
  - vblank_irq: vcount 159->160.
  - vcount_irq: vcount changes to a value equal to lyc. A mid-line lyc write changes vcount_match only; no pulse.
- Swap handshake:
  - On the vblank_irq cycle, swap_req is set.
  - While swap_req=1 and swap_ack=1 at a clk edge: front_sel toggles and swap_req clears on that edge.
  - swap_ack when swap_req=0 is ignored.
  - If swap_req is still 1 at the frame wrap: swap_req clears, front_sel is unchanged, frame_drop pulses one clk.
  - Ack on the same edge as the frame wrap: the ack wins, with no drop.
- en=0: divider, counters and pix_addr hold; dot_strobe, pix_wen and the irq pulses are 0. The swap handshake still responds to swap_ack, but no drop can occur while frozen.
- Reset mid-frame restarts at dot 0 line 0 with front_sel=0. Any pending swap is lost silently (no frame_drop).

Decomposition:
- gfx_timing_pkg: H_VISIBLE, H_TOTAL, V_VISIBLE, V_TOTAL, DOT_CLKS, FB_WORDS=38400, and the derived widths.
- Sub-module frame_mod_counter: parameterized width/max wrap counter with en and synchronous clear, async active-low reset. It is instantiated for div, hcount, vcount and pix_addr.
- Handshake and irq edge logic live in the top module.

Test Plan:
- Reset then en=1 for 280896 clk -> exactly 38400 pix_wen pulses, pix_addr sequence 0..38399, then hcount=0, vcount=0, pix_addr=0.
- Run to vcount 159->160 -> vblank_irq one clk, vblank=1, swap_req=1. swap_ack at clk +100 -> front_sel 0->1 and swap_req=0 on the same edge.
- Hold swap_ack=0 through a whole VBlank -> frame_drop pulse at frame wrap, swap_req=0, front_sel unchanged. Ack coincident with wrap -> toggle, no drop.
- lyc=5 -> vcount_irq once per frame at line 5 entry. Write lyc=vcount mid-line -> vcount_match=1, no irq.
- en=0 for 1000 clk mid-line 50, dot 100 -> all counters and pix_addr frozen, no pulses. Resume gives the exact continuation (frame period grows by 1000).
- rst_b low mid-line 80 with swap pending -> all outputs 0 immediately (async). After release, counting restarts from 0 and no frame_drop occurs.

Source files
------------

// File: rtl/gfx_timing_pkg.sv
// gfx_timing_pkg: GBA dot/line geometry and the counter widths derived from it
package gfx_timing_pkg;
  localparam int DOT_CLKS  = 4;
  localparam int H_VISIBLE = 240;
  localparam int H_TOTAL   = 308;
  localparam int V_VISIBLE = 160;
  localparam int V_TOTAL   = 228;
  localparam int FB_WORDS  = H_VISIBLE * V_VISIBLE;
  localparam int H_W = 9;
  localparam int V_W = 8;
  localparam int A_W = 17;
endpackage

// File: rtl/frame_mod_counter.sv
// frame_mod_counter: modulo-(MAX+1) counter with enable and synchronous clear
module frame_mod_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] LAST = W'(MAX);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q == LAST ? '0 : q + 1'b1;
endmodule

// File: rtl/gfx_frame_scheduler.sv
// gfx_frame_scheduler: dot/line timing, back-buffer write addressing, status irqs
// and the VBlank buffer-swap handshake.
module gfx_frame_scheduler #(
  parameter int DOT_CLKS  = gfx_timing_pkg::DOT_CLKS,
  parameter int H_VISIBLE = gfx_timing_pkg::H_VISIBLE,
  parameter int H_TOTAL   = gfx_timing_pkg::H_TOTAL,
  parameter int V_VISIBLE = gfx_timing_pkg::V_VISIBLE,
  parameter int V_TOTAL   = gfx_timing_pkg::V_TOTAL
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        en,
  input  logic [7:0]  lyc,
  input  logic        swap_ack,
  output logic        dot_strobe,
  output logic [8:0]  hcount,
  output logic [7:0]  vcount,
  output logic        pix_wen,
  output logic [16:0] pix_addr,
  output logic        hblank,
  output logic        vblank,
  output logic        vcount_match,
  output logic        hblank_irq,
  output logic        vblank_irq,
  output logic        vcount_irq,
  output logic        swap_req,
  output logic        front_sel,
  output logic        frame_drop
);
  import gfx_timing_pkg::*;
  localparam int DW = DOT_CLKS > 1 ? $clog2(DOT_CLKS) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DOT_CLKS - 1);
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS    = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] H_PRE    = H_W'(H_VISIBLE - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS    = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_VB_END = V_W'(V_TOTAL - 2);
  logic [DW-1:0]  div;
  logic [V_W-1:0] v_next;
  logic           line_end;
  logic           frame_wrap;
  frame_mod_counter #(.W(DW), .MAX(DOT_CLKS - 1)) u_div (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(1'b0), .q(div)
  );
  frame_mod_counter #(.W(H_W), .MAX(H_TOTAL - 1)) u_hcount (
    .clk(clk), .rst_b(rst_b), .en(dot_strobe), .clr(1'b0), .q(hcount)
  );
  frame_mod_counter #(.W(V_W), .MAX(V_TOTAL - 1)) u_vcount (
    .clk(clk), .rst_b(rst_b), .en(line_end), .clr(1'b0), .q(vcount)
  );
  // The address wraps on its own after the last visible write; the frame clear re-aligns it.
  frame_mod_counter #(.W(A_W), .MAX(H_VISIBLE * V_VISIBLE - 1)) u_addr (
    .clk(clk), .rst_b(rst_b), .en(pix_wen), .clr(frame_wrap), .q(pix_addr)
  );
  always_comb begin
    dot_strobe   = en && div == DIV_LAST;
    line_end     = dot_strobe && hcount == H_LAST;
    frame_wrap   = line_end && vcount == V_LAST;
    v_next       = vcount == V_LAST ? '0 : vcount + 1'b1;
    pix_wen      = dot_strobe && hcount < H_VIS && vcount < V_VIS;
    hblank       = hcount >= H_VIS;
    vblank       = vcount >= V_VIS && vcount <= V_VB_END;
    vcount_match = vcount == lyc;
  end
  // An ack on the wrap edge wins over the drop.
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      hblank_irq <= 1'b0;
      vblank_irq <= 1'b0;
      vcount_irq <= 1'b0;
      swap_req   <= 1'b0;
      front_sel  <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      hblank_irq <= dot_strobe && hcount == H_PRE;
      vblank_irq <= line_end && v_next == V_VIS;
      vcount_irq <= line_end && v_next == lyc;
      frame_drop <= swap_req && !swap_ack && frame_wrap;
      front_sel  <= front_sel ^ (swap_req && swap_ack);
      swap_req   <= (line_end && v_next == V_VIS) ? 1'b1 : swap_req && !swap_ack && !frame_wrap;
    end
endmodule
